tag_lookup_ctrl: RTL and testbench

//  Sequences the direct-mapped tag RAM for one CPU request port: drives index/tag/write, holds per-line valid bits, and compares the stored tag.
//  On a hit, signals completion. On a miss, issues a line-fill request to memory, then writes the new tag and completes.

---
 rtl/tag_lookup_ctrl_pkg.sv | 21 ++
 rtl/tag_lookup_ctrl_valid_array.sv | 29 ++
 rtl/tag_lookup_ctrl.sv | 157 +++++++++++++++
 tb/tb_tag_lookup_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/tag_lookup_ctrl_pkg.sv
// Shared widths, FSM encoding and helpers for the tag lookup controller.
package tag_lookup_ctrl_pkg;

    localparam int INDEX     = 4;
    localparam int TAG       = 4;
    localparam int CACHESIZE = 1 << INDEX;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        READ     = 3'd1,
        CMP      = 3'd2,
        FILL_REQ = 3'd3,
        FILL_WR  = 3'd4,
        RESP     = 3'd5
    } lookupState_e;

    function automatic logic [15:0] satInc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/tag_lookup_ctrl_valid_array.sv
// Per-line valid bits: async clear, synchronous flush-all, single-bit set, combinational read.
module tag_lookup_ctrl_valid_array #(
    parameter int INDEX_W   = 4,
    parameter int CACHESIZE = 1 << INDEX_W
) (
    input  logic               Clk,
    input  logic               Resetn,
    input  logic               FlushAll,
    input  logic               SetEn,
    input  logic [INDEX_W-1:0] SetIdx,
    input  logic [INDEX_W-1:0] RdIdx,
    output logic               RdValid
);

    logic [CACHESIZE-1:0] validBits;

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            validBits <= '0;
        end else if (FlushAll) begin
            validBits <= '0;
        end else if (SetEn) begin
            validBits[SetIdx] <= 1'b1;
        end
    end

    assign RdValid = validBits[RdIdx];

endmodule

// File: rtl/tag_lookup_ctrl.sv
// Direct-mapped tag lookup sequencer: reads the external tag RAM, compares, and
// requests a line fill on a miss before writing the new tag back.
//
// state    | meaning
// IDLE     | waiting for a request; Flush clears all valid bits here
// READ     | tag RAM registers TagOut for the latched index
// CMP      | compare stored tag and valid bit against the request
// FILL_REQ | MemReq held until MemAck
// FILL_WR  | TrWrite pulse, tag RAM writes on the mid-cycle negedge
// RESP     | one-cycle CpuAck
module tag_lookup_ctrl
    import tag_lookup_ctrl_pkg::*;
#(
    parameter int INDEX_W   = INDEX,
    parameter int TAG_W     = TAG,
    parameter int CACHESIZE = 1 << INDEX_W
) (
    input  logic                     Clk,
    input  logic                     Resetn,
    input  logic                     CpuReq,
    input  logic [TAG_W+INDEX_W-1:0] CpuAddr,
    input  logic                     CpuWr,
    input  logic                     Flush,
    output logic                     CpuAck,
    output logic                     CpuHit,
    output logic                     MemReq,
    output logic [TAG_W+INDEX_W-1:0] MemAddr,
    input  logic                     MemAck,
    output logic [INDEX_W-1:0]       TrAddress,
    output logic [TAG_W-1:0]         TrTagIn,
    output logic                     TrWrite,
    input  logic [TAG_W-1:0]         TrTagOut,
    output logic [15:0]              HitCount,
    output logic [15:0]              MissCount
);

    lookupState_e state, stateNext;

    logic [TAG_W-1:0]         reqTag, reqTagNext;
    logic [INDEX_W-1:0]       reqIndex, reqIndexNext;
    logic [15:0]              hitCnt, hitCntNext;
    logic [15:0]              missCnt, missCntNext;
    logic                     cpuAckNext, cpuHitNext, memReqNext, trWriteNext;
    logic [TAG_W+INDEX_W-1:0] memAddrNext;
    logic [INDEX_W-1:0]       trAddressNext;
    logic [TAG_W-1:0]         trTagInNext;
    logic                     lineValid, flushAll, setValid, tagHit;
    logic                     unusedWr;

    // Writes allocate exactly like reads, so the direction bit has no effect here.
    assign unusedWr  = CpuWr;
    assign flushAll  = (state == IDLE) && Flush;
    assign setValid  = (state == FILL_WR);
    assign tagHit    = lineValid && (TrTagOut == reqTag);
    assign HitCount  = hitCnt;
    assign MissCount = missCnt;

    tag_lookup_ctrl_valid_array #(
        .INDEX_W  (INDEX_W),
        .CACHESIZE(CACHESIZE)
    ) u_validArray (
        .Clk     (Clk),
        .Resetn  (Resetn),
        .FlushAll(flushAll),
        .SetEn   (setValid),
        .SetIdx  (reqIndex),
        .RdIdx   (reqIndex),
        .RdValid (lineValid)
    );

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state     <= IDLE;
            reqTag    <= '0;
            reqIndex  <= '0;
            hitCnt    <= '0;
            missCnt   <= '0;
            CpuAck    <= 1'b0;
            CpuHit    <= 1'b0;
            MemReq    <= 1'b0;
            MemAddr   <= '0;
            TrAddress <= '0;
            TrTagIn   <= '0;
            TrWrite   <= 1'b0;
        end else begin
            state     <= stateNext;
            reqTag    <= reqTagNext;
            reqIndex  <= reqIndexNext;
            hitCnt    <= hitCntNext;
            missCnt   <= missCntNext;
            CpuAck    <= cpuAckNext;
            CpuHit    <= cpuHitNext;
            MemReq    <= memReqNext;
            MemAddr   <= memAddrNext;
            TrAddress <= trAddressNext;
            TrTagIn   <= trTagInNext;
            TrWrite   <= trWriteNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:     if (!Flush && CpuReq) stateNext = READ;
            READ:     stateNext = CMP;
            CMP:      stateNext = tagHit ? RESP : FILL_REQ;
            FILL_REQ: if (MemAck) stateNext = FILL_WR;
            FILL_WR:  stateNext = RESP;
            RESP:     stateNext = IDLE;
            default:  stateNext = IDLE;
        endcase
    end

    always_comb begin
        reqTagNext    = reqTag;
        reqIndexNext  = reqIndex;
        hitCntNext    = hitCnt;
        missCntNext   = missCnt;
        cpuAckNext    = 1'b0;
        cpuHitNext    = 1'b0;
        memReqNext    = MemReq;
        memAddrNext   = MemAddr;
        trAddressNext = TrAddress;
        trTagInNext   = TrTagIn;
        trWriteNext   = 1'b0;
        case (state)
            IDLE: begin
                if (!Flush && CpuReq) begin
                    reqTagNext    = CpuAddr[TAG_W+INDEX_W-1 -: TAG_W];
                    reqIndexNext  = CpuAddr[INDEX_W-1:0];
                    trAddressNext = CpuAddr[INDEX_W-1:0];
                end
            end
            CMP: begin
                if (tagHit) begin
                    cpuHitNext = 1'b1;
                    cpuAckNext = 1'b1;
                    hitCntNext = satInc(hitCnt);
                end else begin
                    memReqNext  = 1'b1;
                    memAddrNext = {reqTag, reqIndex};
                    missCntNext = satInc(missCnt);
                end
            end
            FILL_REQ: begin
                if (MemAck) begin
                    memReqNext  = 1'b0;
                    trTagInNext = reqTag;
                    trWriteNext = 1'b1;
                end
            end
            FILL_WR: cpuAckNext = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// Scoreboard bench for tag_lookup_ctrl with a behavioural tag RAM alongside.
module tb_tag_lookup_ctrl;

    logic        Clk = 1'b0;
    logic        Resetn = 1'b0;
    logic        CpuReq = 1'b0;
    logic [7:0]  CpuAddr = 8'h00;
    logic        CpuWr = 1'b0;
    logic        Flush = 1'b0;
    logic        MemAck = 1'b0;
    logic        CpuAck, CpuHit, MemReq, TrWrite;
    logic [7:0]  MemAddr;
    logic [3:0]  TrAddress, TrTagIn, TrTagOut;
    logic [15:0] HitCount, MissCount;

    logic [3:0]  tagRam [16];

    typedef struct {
        logic       hit;
        int         lat;
        logic [7:0] addr;
    } expEntry_t;

    expEntry_t   expQ[$];
    bit          mValid[16];
    logic [3:0]  mTag[16];
    logic [15:0] mHits, mMisses;
    int          testsRun = 0;
    int          testsFailed = 0;

    tag_lookup_ctrl #(.INDEX_W(4), .TAG_W(4)) dut (
        .Clk      (Clk),
        .Resetn   (Resetn),
        .CpuReq   (CpuReq),
        .CpuAddr  (CpuAddr),
        .CpuWr    (CpuWr),
        .Flush    (Flush),
        .CpuAck   (CpuAck),
        .CpuHit   (CpuHit),
        .MemReq   (MemReq),
        .MemAddr  (MemAddr),
        .MemAck   (MemAck),
        .TrAddress(TrAddress),
        .TrTagIn  (TrTagIn),
        .TrWrite  (TrWrite),
        .TrTagOut (TrTagOut),
        .HitCount (HitCount),
        .MissCount(MissCount)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) if (TrWrite) tagRam[TrAddress] <= TrTagIn;
    always @(posedge Clk) TrTagOut <= tagRam[TrAddress];

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] satUp(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic modelReset();
        foreach (mValid[i]) mValid[i] = 1'b0;
        mHits   = 16'd0;
        mMisses = 16'd0;
    endtask

    task automatic doRequest(input logic [7:0] addr, input logic wr, input int ackDelay,
                             input bit withFlush);
        expEntry_t e;
        int  cyc, memCyc, wrPulses;
        bit  done;
        @(negedge Clk);
        CpuReq  = 1'b1;
        CpuAddr = addr;
        CpuWr   = wr;
        if (withFlush) begin
            Flush = 1'b1;
            @(posedge Clk);
            #1 Flush = 1'b0;
            foreach (mValid[i]) mValid[i] = 1'b0;
        end
        e.hit  = mValid[addr[3:0]] && (mTag[addr[3:0]] == addr[7:4]);
        e.lat  = e.hit ? 3 : 5 + ackDelay;
        e.addr = addr;
        expQ.push_back(e);
        @(posedge Clk);
        #1 CpuAddr = ~addr;
        cyc = 0; memCyc = 0; wrPulses = 0; done = 1'b0;
        while (!done && cyc < 60) begin
            @(negedge Clk);
            cyc++;
            if (TrWrite) wrPulses++;
            if (MemReq) begin
                memCyc++;
                if (memCyc == 1) checkVal("memAddr", {24'd0, MemAddr}, {24'd0, addr});
                if (memCyc == ackDelay + 1) MemAck = 1'b1;
            end else begin
                MemAck = 1'b0;
            end
            if (CpuAck) begin
                done   = 1'b1;
                CpuReq = 1'b0;
                MemAck = 1'b0;
                e = expQ.pop_front();
                checkVal("cpuHit", {31'd0, CpuHit}, {31'd0, e.hit});
                checkVal("ackLatency", cyc, e.lat);
                checkVal("memReqCycles", memCyc, e.hit ? 0 : ackDelay + 1);
                checkVal("trWritePulses", wrPulses, e.hit ? 0 : 1);
                if (e.hit) begin
                    mHits = satUp(mHits);
                end else begin
                    mMisses = satUp(mMisses);
                    mValid[e.addr[3:0]] = 1'b1;
                    mTag[e.addr[3:0]]   = e.addr[7:4];
                end
                checkVal("hitCount", {16'd0, HitCount}, {16'd0, mHits});
                checkVal("missCount", {16'd0, MissCount}, {16'd0, mMisses});
            end
        end
        checkVal("ackSeen", {31'd0, done}, 32'd1);
        if (!done) begin
            CpuReq = 1'b0;
            MemAck = 1'b0;
            expQ.delete();
        end
    endtask

    initial begin
        int waitCyc;
        modelReset();
        #23;
        checkVal("rstCpuAck", {31'd0, CpuAck}, 32'd0);
        checkVal("rstCpuHit", {31'd0, CpuHit}, 32'd0);
        checkVal("rstMemReq", {31'd0, MemReq}, 32'd0);
        checkVal("rstMemAddr", {24'd0, MemAddr}, 32'd0);
        checkVal("rstTrAddress", {28'd0, TrAddress}, 32'd0);
        checkVal("rstTrTagIn", {28'd0, TrTagIn}, 32'd0);
        checkVal("rstTrWrite", {31'd0, TrWrite}, 32'd0);
        checkVal("rstHitCount", {16'd0, HitCount}, 32'd0);
        checkVal("rstMissCount", {16'd0, MissCount}, 32'd0);
        @(negedge Clk);
        Resetn = 1'b1;

        doRequest(8'h35, 1'b0, 5, 1'b0);
        doRequest(8'h35, 1'b0, 0, 1'b0);
        doRequest(8'h75, 1'b0, 2, 1'b0);
        doRequest(8'h35, 1'b0, 0, 1'b0);
        checkVal("missAfterEvict", {16'd0, MissCount}, 32'd3);
        doRequest(8'hA2, 1'b1, 1, 1'b0);
        doRequest(8'hA2, 1'b0, 0, 1'b0);
        doRequest(8'h35, 1'b1, 0, 1'b0);
        doRequest(8'h75, 1'b0, 0, 1'b0);
        doRequest(8'h75, 1'b0, 0, 1'b1);

        // Reset in the middle of a fill.
        @(negedge Clk);
        CpuReq  = 1'b1;
        CpuAddr = 8'h35;
        @(posedge Clk);
        #1 CpuReq = 1'b0;
        waitCyc = 0;
        while (!MemReq && waitCyc < 10) begin
            @(negedge Clk);
            waitCyc++;
        end
        checkVal("fillReached", {31'd0, MemReq}, 32'd1);
        #2 Resetn = 1'b0;
        #1;
        checkVal("rstMidMemReq", {31'd0, MemReq}, 32'd0);
        checkVal("rstMidTrWrite", {31'd0, TrWrite}, 32'd0);
        checkVal("rstMidCpuAck", {31'd0, CpuAck}, 32'd0);
        checkVal("rstMidMissCount", {16'd0, MissCount}, 32'd0);
        modelReset();
        @(negedge Clk);
        Resetn = 1'b1;
        doRequest(8'hA2, 1'b0, 0, 1'b0);
        doRequest(8'h35, 1'b0, 1, 1'b0);

        // Saturation of the hit counter.
        @(negedge Clk);
        force dut.hitCnt = 16'hFFFE;
        #1 release dut.hitCnt;
        mHits = 16'hFFFE;
        checkVal("hitPreset", {16'd0, HitCount}, 32'h0000FFFE);
        for (int i = 0; i < 3; i++) doRequest(8'h35, 1'b0, 0, 1'b0);
        checkVal("hitSaturated", {16'd0, HitCount}, 32'h0000FFFF);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
